// File: rtl/ifu_pkg.sv
// IFU shared constants: reset/exception addresses, instruction-memory window,
// next-PC select encodings and the fetch-address legality check.
package ifu_pkg;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] IM_BASE    = 32'h0000_3000;
  localparam logic [31:0] IM_LAST    = 32'h0000_4FFC;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'd0,
    NPC_BR   = 2'd1,
    NPC_JUMP = 2'd2,
    NPC_REG  = 2'd3
  } npc_sel_e;

  // A fetch address is legal only when word-aligned and inside the IM window.
  function automatic logic addr_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IM_BASE) || (addr > IM_LAST);
  endfunction

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC selection for the IFU.
// Priority: exc_req > eret > stall (hold) > npc_sel.
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [3:0]  id_pc4_hi,
  input  npc_sel_e    npc_sel,
  input  logic [31:0] br_target,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        stall,
  output logic [31:0] npc,
  output logic [31:0] pc4,
  output logic        redirect
);

  logic [31:0] sel_target;

  // 32-bit modulo add: 0xFFFF_FFFC + 4 wraps to 0.
  assign pc4 = pc + 32'd4;

  always_comb begin
    sel_target = pc4;
    unique case (npc_sel)
      NPC_SEQ:  sel_target = pc4;
      NPC_BR:   sel_target = br_target;
      NPC_JUMP: sel_target = {id_pc4_hi, j_index, 2'b00};
      NPC_REG:  sel_target = jr_target;
      default:  sel_target = pc4;
    endcase
  end

  always_comb begin
    npc      = pc;
    redirect = 1'b0;
    if (exc_req) begin
      npc      = EXC_VECTOR;
      redirect = 1'b1;
    end else if (eret) begin
      npc      = epc;
      redirect = 1'b1;
    end else if (stall) begin
      npc      = pc;
    end else begin
      npc      = sel_target;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, IF/ID pipeline register and next-PC mux.
// Optional fetch-address checking is enabled by defining IFU_ADDR_CHECK_EN.
module ifu
  import ifu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] br_target,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        fetch_exc
);

  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] pc4;
  logic        redirect;
  logic [31:0] fetch_word;

  ifu_npc u_npc (
    .pc        (pc),
    .id_pc4_hi (id_pc4[31:28]),
    .npc_sel   (npc_sel_e'(npc_sel)),
    .br_target (br_target),
    .j_index   (j_index),
    .jr_target (jr_target),
    .exc_req   (exc_req),
    .eret      (eret),
    .epc       (epc),
    .stall     (stall),
    .npc       (npc),
    .pc4       (pc4),
    .redirect  (redirect)
  );

  assign im_pc = pc;

`ifdef IFU_ADDR_CHECK_EN
  logic fetch_err;
  logic fetch_exc_q;

  assign fetch_err  = addr_err(pc);
  // A faulting fetch enters IF/ID as a NOP but keeps its PC for the handler.
  assign fetch_word = fetch_err ? 32'h0 : im_instr;
  assign fetch_exc  = fetch_exc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_exc_q <= 1'b0;
    end else if (redirect) begin
      fetch_exc_q <= 1'b0;
    end else if (!stall) begin
      fetch_exc_q <= fetch_err;
    end
  end
`else
  assign fetch_word = im_instr;
  assign fetch_exc  = 1'b0;
`endif

  // id_valid=1 marks a real instruction in IF/ID; a redirect inserts a bubble
  // (id_valid=0, id_instr=0) and leaves id_pc/id_pc4 at their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= PC_RESET;
      id_instr <= 32'h0;
      id_pc    <= PC_RESET;
      id_pc4   <= PC_RESET + 32'd4;
      id_valid <= 1'b0;
    end else if (redirect) begin
      pc       <= npc;
      id_instr <= 32'h0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      pc       <= npc;
      id_instr <= fetch_word;
      id_pc    <= pc;
      id_pc4   <= pc4;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios followed by random stimulus,
// checked against a rule-level reference model of the fetch stage.
module tb_ifu;

`ifdef IFU_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [31:0] br_target;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        fetch_exc;

  int n_vec;
  int n_err;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_id_instr;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_pc4;
  logic        m_id_valid;
  logic        m_fexc;

  ifu dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .npc_sel   (npc_sel),
    .br_target (br_target),
    .j_index   (j_index),
    .jr_target (jr_target),
    .exc_req   (exc_req),
    .eret      (eret),
    .epc       (epc),
    .im_pc     (im_pc),
    .im_instr  (im_instr),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .id_pc4    (id_pc4),
    .id_valid  (id_valid),
    .fetch_exc (fetch_exc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  always_comb im_instr = mem(im_pc);

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h4FFC);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] target;
    bit          err;
    if (reset) begin
      m_pc = 32'h3000; m_id_instr = 0; m_id_pc = 32'h3000; m_id_pc4 = 32'h3004;
      m_id_valid = 0; m_fexc = 0;
    end else if (exc_req || eret) begin
      m_pc = exc_req ? 32'h4180 : epc;
      m_id_instr = 0; m_id_valid = 0; m_fexc = 0;
    end else if (!stall) begin
      case (npc_sel)
        2'd0:    target = m_pc + 4;
        2'd1:    target = br_target;
        2'd2:    target = {m_id_pc4[31:28], j_index, 2'b00};
        default: target = jr_target;
      endcase
      err = CHECK_EN && bad_addr(m_pc);
      m_id_instr = err ? 32'h0 : mem(m_pc);
      m_id_pc    = m_pc;
      m_id_pc4   = m_pc + 4;
      m_id_valid = 1;
      m_fexc     = err;
      m_pc       = target;
    end
  endtask

  task automatic check_all();
    chk("im_pc", im_pc, m_pc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
    chk("fetch_exc", {31'b0, fetch_exc}, {31'b0, m_fexc});
    chk("id_instr", id_instr, m_id_instr);
    if (m_id_valid || m_fexc) begin
      chk("id_pc", id_pc, m_id_pc);
      chk("id_pc4", id_pc4, m_id_pc4);
    end
  endtask

  // Driver: one clock, then sample #1 after the edge and compare.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_all();
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; npc_sel = 2'd0; exc_req = 0; eret = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_pc = 0; m_id_instr = 0; m_id_pc = 0; m_id_pc4 = 0; m_id_valid = 0; m_fexc = 0;
    idle_inputs();
    br_target = 0; j_index = 0; jr_target = 0; epc = 0;

    // Reset values, and reset overriding stall/exc/eret
    reset = 1;
    tick();
    chk("rst_pc", im_pc, 32'h3000);
    chk("rst_id_pc4", id_pc4, 32'h3004);
    stall = 1; exc_req = 1; eret = 1; epc = 32'h3100;
    tick();
    chk("rst_override_pc", im_pc, 32'h3000);

    // Sequential fetch
    idle_inputs();
    tick(); chk("seq_pc1", im_pc, 32'h3004); chk("seq_id_pc1", id_pc, 32'h3000);
    tick(); chk("seq_pc2", im_pc, 32'h3008); chk("seq_id_pc2", id_pc, 32'h3004);
    tick(); tick(); chk("seq_pc4", im_pc, 32'h3010);

    // Branch with delay slot
    npc_sel = 2'd1; br_target = 32'h3040;
    tick();
    chk("br_pc", im_pc, 32'h3040);
    chk("br_slot_pc", id_pc, 32'h3010);
    chk("br_slot_valid", {31'b0, id_valid}, 32'd1);
    npc_sel = 2'd0;

    // Stalled jump
    stall = 1; npc_sel = 2'd2; j_index = 26'h0000C80;
    tick(); chk("stall1_pc", im_pc, 32'h3040);
    tick(); chk("stall2_pc", im_pc, 32'h3040); chk("stall2_id_pc", id_pc, 32'h3010);
    stall = 0;
    tick(); chk("jump_pc", im_pc, 32'h3200);
    npc_sel = 2'd0;

    // Exception during stall, then eret
    npc_sel = 2'd3; jr_target = 32'h3020;
    tick(); chk("jr_pc", im_pc, 32'h3020);
    npc_sel = 2'd0; stall = 1; exc_req = 1;
    tick(); chk("exc_pc", im_pc, 32'h4180); chk("exc_bubble", {31'b0, id_valid}, 32'd0);
    stall = 0; exc_req = 0; eret = 1; epc = 32'h3020;
    tick(); chk("eret_pc", im_pc, 32'h3020); chk("eret_bubble", {31'b0, id_valid}, 32'd0);
    exc_req = 1; eret = 1; epc = 32'h3100;
    tick(); chk("exc_eret_pc", im_pc, 32'h4180);
    idle_inputs();
    tick();

    // Reset in the middle of a stall
    stall = 1; tick(); tick();
    reset = 1; tick();
    idle_inputs();
    tick(); chk("post_rst_id_pc", id_pc, 32'h3000); chk("post_rst_pc", im_pc, 32'h3004);

    // Fetch address errors and PC wrap
    npc_sel = 2'd3; jr_target = 32'h3002;
    tick(); npc_sel = 2'd0;
    tick();
    chk("mis_fexc", {31'b0, fetch_exc}, {31'b0, CHECK_EN});
    chk("mis_id_pc", id_pc, 32'h3002);
    chk("mis_instr", id_instr, CHECK_EN ? 32'h0 : mem(32'h3002));
    npc_sel = 2'd3; jr_target = 32'h5000;
    tick(); npc_sel = 2'd0;
    tick(); chk("oob_fexc", {31'b0, fetch_exc}, {31'b0, CHECK_EN});
    npc_sel = 2'd3; jr_target = 32'hFFFF_FFFC;
    tick(); npc_sel = 2'd0;
    tick(); chk("wrap_pc", im_pc, 32'h0);
    reset = 1; tick(); reset = 0;

    // Random stimulus
    for (int i = 0; i < 600; i++) begin
      reset   = ($urandom_range(0, 99) < 2);
      stall   = ($urandom_range(0, 99) < 25);
      exc_req = ($urandom_range(0, 99) < 5);
      eret    = ($urandom_range(0, 99) < 5);
      npc_sel = ($urandom_range(0, 99) < 60) ? 2'd0 : 2'($urandom_range(1, 3));
      br_target = 32'h3000 + (32'($urandom_range(0, 2047)) << 2);
      jr_target = ($urandom_range(0, 9) == 0) ? $urandom : 32'h3000 + (32'($urandom_range(0, 2047)) << 2);
      epc       = 32'h3000 + (32'($urandom_range(0, 2047)) << 2);
      j_index   = 26'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
